// File: rtl/counter_bus_pkg.sv
// Shared types and constants for the counter bus master.
package counter_bus_pkg;

   typedef enum logic [1:0] {
      OP_INC_N = 2'b00,
      OP_LOAD  = 2'b01,
      OP_READ  = 2'b10,
      OP_CLEAR = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INC,
      ST_LOAD,
      ST_READ,
      ST_VERIFY
   } state_t;

   localparam int RD_WAIT_MAX = 7;
   localparam int RD_WAIT_W   = 3;

endpackage

// File: rtl/counter_bus_oe_timer.sv
// Output-enable window timer: holds oe for load_val+1 cycles after start and
// flags the last of them as the sample cycle.
module counter_bus_oe_timer
   import counter_bus_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [RD_WAIT_W-1:0] load_val,
   output logic                 oe,
   output logic                 sample
);

   logic [RD_WAIT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe    <= 1'b0;
         count <= '0;
      end else if (start) begin
         oe    <= 1'b1;
         count <= load_val;
      end else if (oe) begin
         if (count == '0) begin
            oe <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   assign sample = oe && (count == '0);

endmodule

// File: rtl/counter_bus_master.sv
// Bus master sequencing inc/load/oe strobes of an 8-bit counter peripheral.
// Define COUNTER_BUS_VERIFY_EN to read back and compare after every LOAD/CLEAR.
module counter_bus_master
   import counter_bus_pkg::*;
#(
   parameter int RD_WAIT = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       cnt_inc,
   output logic       cnt_load,
   output logic [7:0] cnt_d,
   output logic       cnt_oe,
   input  logic [7:0] cnt_q
);

   state_t     state;
   cmd_op_t    op;
   logic [7:0] remain;
   logic       accept;
   logic       rd_start;
   logic       rd_sample;

   assign op     = cmd_op_t'(cmd_op);
   assign accept = cmd_valid && cmd_ready;

`ifdef COUNTER_BUS_VERIFY_EN
   logic [7:0] ld_val;
   // The LOAD strobe cycle doubles as the launch of the read-back window.
   assign rd_start = (accept && op == OP_READ) || (state == ST_LOAD);
`else
   assign rd_start = accept && op == OP_READ;
   assign rsp_err  = 1'b0;
`endif

   counter_bus_oe_timer u_oe_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (rd_start),
      .load_val (RD_WAIT_W'(RD_WAIT)),
      .oe       (cnt_oe),
      .sample   (rd_sample)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         remain    <= 8'h00;
         cnt_inc   <= 1'b0;
         cnt_load  <= 1'b0;
         cnt_d     <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
`ifdef COUNTER_BUS_VERIFY_EN
         ld_val    <= 8'h00;
         rsp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  cmd_ready <= 1'b0;
                  case (op)
                     OP_INC_N: begin
                        state   <= ST_INC;
                        cnt_inc <= 1'b1;
                        remain  <= cmd_data;
                     end
                     OP_LOAD, OP_CLEAR: begin
                        state    <= ST_LOAD;
                        cnt_load <= 1'b1;
                        cnt_d    <= (op == OP_LOAD) ? cmd_data : 8'h00;
`ifdef COUNTER_BUS_VERIFY_EN
                        ld_val   <= (op == OP_LOAD) ? cmd_data : 8'h00;
`endif
                     end
                     OP_READ: state <= ST_READ;
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_INC: begin
               // remain counts strobe cycles left including this one; 0 wraps to 256.
               if (remain == 8'd1) begin
                  cnt_inc   <= 1'b0;
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
               end else begin
                  remain <= remain - 8'd1;
               end
            end
            ST_LOAD: begin
               cnt_load <= 1'b0;
               cnt_d    <= 8'h00;
`ifdef COUNTER_BUS_VERIFY_EN
               state    <= ST_VERIFY;
`else
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
`endif
            end
            ST_READ, ST_VERIFY: begin
               if (rsp_valid) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
               end else if (rd_sample) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= cnt_q;
`ifdef COUNTER_BUS_VERIFY_EN
                  rsp_err   <= (state == ST_VERIFY) && (cnt_q != ld_val);
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_bus_master.sv
// Self-checking bench for counter_bus_master: directed table, reset corner
// cases and random back-to-back commands against a spec-level timing model.
module tb_counter_bus_master;

   localparam int RW = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, rsp_err, cnt_inc, cnt_load, cnt_oe;
   logic [7:0] rsp_data, cnt_d, cnt_q;

   int checks = 0;
   int errors = 0;

   logic [7:0] periph = 8'h00;
   logic [7:0] junk = 8'h00;
   logic [7:0] corrupt = 8'h00;
   int         model_val = 0;
   logic [7:0] last_rsp = 8'h00;

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [12];

   always #5 clk = ~clk;

   counter_bus_master #(.RD_WAIT(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .cnt_inc   (cnt_inc),
      .cnt_load  (cnt_load),
      .cnt_d     (cnt_d),
      .cnt_oe    (cnt_oe),
      .cnt_q     (cnt_q)
   );

   // Behavioural counter peripheral; drives junk whenever oe is low.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        periph <= 8'h00;
      else if (cnt_load) periph <= cnt_d;
      else if (cnt_inc)  periph <= periph + 8'd1;
   end
   always @(negedge clk) junk <= 8'($urandom);
   assign cnt_q = cnt_oe ? (periph ^ corrupt) : junk;

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((int'(cnt_inc) + int'(cnt_load) + int'(cnt_oe)) > 1 || (!cnt_load && cnt_d != 8'h00)) begin
            errors++;
            $display("FAIL excl: inc=%0b load=%0b oe=%0b d=%02h, required <=1 strobe and d=00 without load",
                     cnt_inc, cnt_load, cnt_oe, cnt_d);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one command and checks every cycle up to and including the cycle
   // in which cmd_ready returns, leaving the bench there for a back-to-back accept.
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input bit use_tbl, input logic [7:0] tbl_exp);
      int wc = 0;
      int n, len, inc_hi, load_k, oe_lo, oe_hi, rsp_k;
      logic [7:0] exp_v, ldv;
      logic exp_err;
      logic [21:0] act, exp;
      while (cmd_ready !== 1'b1 && wc < 20) begin
         @(posedge clk); #1;
         wc++;
      end
      check("ready_wait", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk); #1;
      cmd_op   = 2'($urandom);
      cmd_data = 8'($urandom);
      n = (d == 8'h00) ? 256 : int'(d);
      inc_hi = 0; load_k = 0; oe_lo = 0; oe_hi = -1; rsp_k = 0; len = 2;
      exp_v = 8'(model_val); exp_err = 1'b0; ldv = 8'h00;
      case (op)
         2'b00: begin
            inc_hi = n;
            len = n + 1;
            model_val = (model_val + n) % 256;
         end
         2'b01, 2'b11: begin
            load_k = 1;
            ldv = (op == 2'b01) ? d : 8'h00;
            model_val = int'(ldv);
`ifdef COUNTER_BUS_VERIFY_EN
            oe_lo = 2; oe_hi = 2 + RW; rsp_k = 3 + RW; len = 4 + RW;
            exp_v = ldv ^ corrupt;
            exp_err = (corrupt != 8'h00);
`else
            len = 2;
`endif
         end
         default: begin
            oe_lo = 1; oe_hi = 1 + RW; rsp_k = 2 + RW; len = 3 + RW;
            exp_v = use_tbl ? tbl_exp : 8'(model_val);
         end
      endcase
      cmd_valid = (1 < len) ? 1'($urandom) : 1'b0;
      for (int k = 1; k <= len; k++) begin
         if (k == rsp_k) last_rsp = exp_v;
         exp = {k == len, k <= inc_hi, k == load_k, (k == load_k) ? ldv : 8'h00,
                (k >= oe_lo) && (k <= oe_hi), k == rsp_k, (k == rsp_k) && exp_err, last_rsp};
         act = {cmd_ready, cnt_inc, cnt_load, cnt_d, cnt_oe, rsp_valid, rsp_err, rsp_data};
         check($sformatf("op%0d_d%02h_cyc%0d {rdy,inc,ld,d,oe,rv,err,rd}", op, d, k), 32'(act), 32'(exp));
         if (k < len) begin
            @(posedge clk); #1;
            cmd_valid = (k + 1 < len) ? 1'($urandom) : 1'b0;
         end
      end
   endtask

   initial begin
      tbl[0]  = '{2'b00, 8'd3,  8'h00};
      tbl[1]  = '{2'b10, 8'h00, 8'h03};
      tbl[2]  = '{2'b01, 8'hA5, 8'h00};
      tbl[3]  = '{2'b10, 8'h00, 8'hA5};
      tbl[4]  = '{2'b11, 8'h77, 8'h00};
      tbl[5]  = '{2'b10, 8'h00, 8'h00};
      tbl[6]  = '{2'b01, 8'hFF, 8'h00};
      tbl[7]  = '{2'b00, 8'h00, 8'h00};
      tbl[8]  = '{2'b10, 8'h00, 8'hFF};
      tbl[9]  = '{2'b00, 8'h01, 8'h00};
      tbl[10] = '{2'b10, 8'h00, 8'h00};
      tbl[11] = '{2'b10, 8'h00, 8'h00};

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_err, rsp_data, cnt_inc, cnt_load, cnt_d, cnt_oe}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("ready_before_edge", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      check("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         do_cmd(tbl[i].op, tbl[i].data, 1'b1, tbl[i].exp);
         $display("vector %0d op=%0d data=%02h rsp_data=%02h", i, tbl[i].op, tbl[i].data, rsp_data);
      end

      // Reset in the 4th strobe cycle of INC_N 10.
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'd10;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("rst_mid_inc_active", {31'b0, cnt_inc}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_drop", 32'({cnt_inc, cnt_load, cnt_oe, cmd_ready, rsp_valid}), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      model_val = 0;
      last_rsp  = 8'h00;
      @(posedge clk); #1;
      check("rst_ready_after", 32'({cmd_ready, cnt_inc, rsp_valid}), 32'b100);
      $display("mid-op reset sequence done ready=%0b", cmd_ready);
      do_cmd(2'b10, 8'h00, 1'b1, 8'h00);

`ifdef COUNTER_BUS_VERIFY_EN
      corrupt = 8'h01;
      do_cmd(2'b01, 8'h3C, 1'b0, 8'h00);
      $display("verify forced: rsp_data=%02h rsp_err=%0b", rsp_data, rsp_err);
      corrupt = 8'h00;
      do_cmd(2'b01, 8'h3C, 1'b0, 8'h00);
      $display("verify clean: rsp_data=%02h rsp_err=%0b", rsp_data, rsp_err);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [1:0] rop;
         logic [7:0] rdat;
         rop  = 2'($urandom_range(0, 3));
         rdat = 8'($urandom);
         do_cmd(rop, rdat, 1'b0, 8'h00);
         $display("random %0d op=%0d data=%02h model=%02h rsp_data=%02h", i, rop, rdat, 8'(model_val), rsp_data);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_bus_master.md
# counter_bus_master

Bus master that drives the control strobes of an 8-bit loadable up-counter peripheral (increment, load, output-enable) and reads its value back. It accepts single commands on a valid/ready interface, sequences the counter's strobes cycle-accurately, and returns read data on a response interface. It sits between a host sequencer and a counter peripheral whose strobes are sampled on the same `clk`.

## Interface
Parameters:
- `RD_WAIT`, default 1: cycles `cnt_oe` is held before `cnt_q` is sampled; legal range 0–7.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: master idle and able to accept; high only in IDLE.
- `cmd_op` in 2: 00 INC_N, 01 LOAD, 10 READ, 11 CLEAR.
- `cmd_data` in 8: INC_N count (0 means 256) or LOAD value.
- `rsp_valid` out 1: one-cycle pulse with read result.
- `rsp_data` out 8: sampled counter value; held until the next response.
- `rsp_err` out 1: verify mismatch; valid with `rsp_valid` (always 0 without `COUNTER_BUS_VERIFY_EN`).
- `cnt_inc` out 1: increment strobe to peripheral.
- `cnt_load` out 1: load strobe to peripheral.
- `cnt_d` out 8: load data to peripheral.
- `cnt_oe` out 1: peripheral output enable.
- `cnt_q` in 8: peripheral value; valid only while `cnt_oe` is high.

## Operation
- Reset: state IDLE, all outputs 0, `cmd_ready` 1 one cycle after `rst_n` deasserts (0 during reset).
- Accept on `cmd_valid && cmd_ready`; `cmd_op` and `cmd_data` latched at the accept edge.
- States: IDLE, INC, LOAD, READ, and VERIFY (macro only).
- INC_N: `cnt_inc` high for exactly N consecutive cycles; 8-bit remaining count, 0 decodes as 256; then IDLE. No response.
- LOAD: `cnt_load` high with `cnt_d` = value for exactly 1 cycle, then IDLE, or VERIFY when the macro is defined. No response unless VERIFY.
- CLEAR: identical to LOAD with value 0x00.
- READ: `cnt_oe` high for RD_WAIT+1 cycles; `cnt_q` sampled on the last of them; `rsp_valid` pulses the following cycle; then IDLE.
- Mutual exclusion: at most one of `cnt_inc`, `cnt_load`, `cnt_oe` is high in any cycle. `cnt_d` is 0 whenever `cnt_load` is low.
- Commands are never queued. `cmd_valid` while busy is ignored, not lost, because `cmd_ready` is low.
- Reset mid-operation: strobes drop immediately (asynchronous), the operation is abandoned, and no response is issued.

## Timing
- Accept at edge T. The first strobe is registered and visible in cycle T+1.
- INC_N: `cnt_inc` high cycles T+1..T+N. `cmd_ready` returns in cycle T+N+1.
- LOAD/CLEAR: strobe in T+1. `cmd_ready` in T+2, or in T+2+RD_WAIT+2 with verify.
- READ: `cnt_oe` in T+1..T+1+RD_WAIT, sample at the end of T+1+RD_WAIT, `rsp_valid` in T+2+RD_WAIT, `cmd_ready` in T+3+RD_WAIT.
- Back-to-back: the next accept is possible in the first cycle `cmd_ready` is high. There is no bubble beyond that.

## Configuration
- `COUNTER_BUS_VERIFY_EN` defined: after LOAD/CLEAR, enter VERIFY. VERIFY performs a READ sequence (same timing) and compares `cnt_q` with the loaded value. `rsp_valid` pulses with `rsp_data` = sampled value and `rsp_err` = (sampled != loaded).
- Undefined: no VERIFY state, LOAD/CLEAR produce no response, and `rsp_err` is tied to 0.

## Structure
- Package `counter_bus_pkg`: `cmd_op` enum (OP_INC_N, OP_LOAD, OP_READ, OP_CLEAR), state enum, and the `RD_WAIT` maximum constant (7).
- Sub-module `counter_bus_oe_timer`: loadable 3-bit down-counter generating the `cnt_oe` window and the sample strobe. It is shared by READ and VERIFY.

## Test plan
- Reset then INC_N data=3 -> `cnt_inc` high exactly 3 cycles from T+1; a behavioural counter model reads 3.
- LOAD 0xA5 then READ with RD_WAIT=1 -> `cnt_oe` 2 cycles, `rsp_valid` at T+3 with `rsp_data`=0xA5.
- INC_N data=0 from 0xFF -> 256 `cnt_inc` cycles; the counter wraps back to 0xFF, and READ returns 0xFF.
- VERIFY build: LOAD 0x3C with the model forcing `cnt_q`=0x3D -> `rsp_valid` with `rsp_data`=0x3D and `rsp_err`=1. A correct model gives `rsp_err`=0.
- `rst_n` low during INC_N count 10 at cycle 4 -> strobes drop asynchronously, no `rsp_valid`, `cmd_ready`=1 after release.
- Mutual-exclusion assertion over random back-to-back commands -> never more than one strobe high, and `cmd_ready` is never high outside IDLE.
